// File: rtl/display_pkg.sv
// display_pkg: shared constants, types and helpers for the 4-digit display scan controller.
package display_pkg;

  localparam int unsigned DIGIT_CYCLES_DEF = 12500;
  localparam int unsigned BLANK_CYCLES_DEF = 500;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned WORD_W     = NUM_DIGITS * NIB_W;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DIG_W      = NUM_DIGITS;
  localparam int unsigned IDX_W      = 2;

  // Active-low segment codes, bit6=a .. bit0=g
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;
  localparam logic [DIG_W-1:0] DIG_OFF = 4'b1111;
  localparam logic [SEG_W-1:0] SEG_0   = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1   = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2   = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3   = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4   = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5   = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6   = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7   = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9   = 7'b0000100;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Display word, d0 is the rightmost digit
  typedef struct packed {
    logic [NIB_W-1:0] d3;
    logic [NIB_W-1:0] d2;
    logic [NIB_W-1:0] d1;
    logic [NIB_W-1:0] d0;
  } disp_word_t;

  // Select the nibble for digit slot i
  function automatic logic [NIB_W-1:0] nibble_at(input disp_word_t w, input logic [IDX_W-1:0] i);
    logic [NIB_W-1:0] n;
    n = w.d0;
    case (i)
      2'd1:    n = w.d1;
      2'd2:    n = w.d2;
      2'd3:    n = w.d3;
      default: n = w.d0;
    endcase
    return n;
  endfunction

  // True when digit i is a leading zero (itself and all higher digits zero); digit 0 never blanks
  function automatic logic lz_blank(input disp_word_t w, input logic [IDX_W-1:0] i);
    logic b;
    b = 1'b0;
    case (i)
      2'd3:    b = (w.d3 == '0);
      2'd2:    b = ({w.d3, w.d2} == '0);
      2'd1:    b = ({w.d3, w.d2, w.d1} == '0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low 7-segment code; non-decimal nibbles go dark.
module seg7_decode
  import display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  // Lookup table for digits 0..9
  always_comb begin
    seg_c = SEG_OFF;
    case (nibble)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 4-digit 7-segment scanner with blank guard per slot
// and a pending/shadow word buffer swapped only at frame boundaries (tear-free).
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros on digits 3..1).
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = DIGIT_CYCLES_DEF,
  parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WORD_W-1:0] digits_in,
  output logic [SEG_W-1:0]  segmentos,
  output logic [DIG_W-1:0]  displays,
  output logic              frame_tick
);

  localparam int unsigned CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, eff_cnt;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             paused_q, paused_d;

  disp_word_t       pending_q, shadow_q;
  logic [NIB_W-1:0] cur_nib;
  logic [SEG_W-1:0] dec_seg_c;
  logic [SEG_W-1:0] seg_d;
  logic [DIG_W-1:0] dig_d;
  logic             tick_d;
  logic             blank_lz;

  // Scan state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      paused_q <= paused_d;
    end
  end

  // Next-state: slot counter, digit index, BLANK/SHOW; a pause restarts the held slot from 0
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    paused_d = paused_q;
    eff_cnt  = paused_q ? '0 : cnt_q;
    if (!enable) begin
      state_d  = ST_BLANK;
      paused_d = 1'b1;
    end else begin
      paused_d = 1'b0;
      if (eff_cnt == LAST_CNT) begin
        cnt_d   = '0;
        idx_d   = idx_q + IDX_W'(1);
        state_d = ST_BLANK;
      end else begin
        cnt_d = eff_cnt + CNT_W'(1);
        if (eff_cnt == BLANK_END) state_d = ST_SHOW;
      end
    end
  end

  assign cur_nib = nibble_at(shadow_q, idx_q);

  seg7_decode u_seg7_decode (
    .nibble (cur_nib),
    .seg_c  (dec_seg_c)
  );

  // Output decode: lit digit in SHOW, dark otherwise; tick flags the upcoming last cycle of digit 3
  always_comb begin
    seg_d  = SEG_OFF;
    dig_d  = DIG_OFF;
    tick_d = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank_lz = lz_blank(shadow_q, idx_q);
`else
    blank_lz = 1'b0;
`endif
    if (enable && (state_q == ST_SHOW)) begin
      dig_d = ~(DIG_W'(1) << idx_q);
      seg_d = blank_lz ? SEG_OFF : dec_seg_c;
    end
    tick_d = enable && (idx_d == LAST_IDX) && (cnt_d == LAST_CNT);
  end

  // Registered display outputs and frame tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      segmentos  <= SEG_OFF;
      displays   <= DIG_OFF;
      frame_tick <= 1'b0;
    end else begin
      segmentos  <= seg_d;
      displays   <= dig_d;
      frame_tick <= tick_d;
    end
  end

  // Word buffer: accept into pending, promote to shadow at the frame boundary
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      shadow_q   <= '0;
      load_ready <= 1'b1;
    end else begin
      if (frame_tick && !load_ready) begin
        shadow_q   <= pending_q;
        load_ready <= 1'b1;
      end
      if (load_valid && load_ready) begin
        pending_q  <= disp_word_t'(digits_in);
        load_ready <= 1'b0;
      end
    end
  end

endmodule
